// File: rtl/seq_tx.sv
// Serial "1001" pattern transmitter: shifts a parallel frame out MSB-first and
// counts overlapping "1001" matches in the sent bits. SEQ_TX_PARITY_EN appends an even-parity bit.
module seq_tx #(
  parameter int WIDTH = 25,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic             LOAD_READY,
  output logic             X,
  output logic             X_VALID,
  output logic             DONE,
  output logic [CNT_W-1:0] MATCH_CNT
);

  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef SEQ_TX_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd3;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [BIT_W-1:0] bcnt;
  logic [2:0]       hist;
  logic [1:0]       fill;
  logic             hit;
`ifdef SEQ_TX_PARITY_EN
  logic             par;
`endif

  // hist[2] is the oldest of the last three bits; fill guards against matches
  // that would need bits from before the frame start.
  assign hit = sreg[WIDTH-1] && (fill == 2'd3) && (hist == 3'b100);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      bcnt      <= '0;
      hist      <= '0;
      fill      <= '0;
      MATCH_CNT <= '0;
`ifdef SEQ_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (LOAD_VALID) begin
            state     <= ST_SHIFT;
            sreg      <= LOAD_DATA;
            bcnt      <= BIT_W'(WIDTH - 1);
            hist      <= '0;
            fill      <= '0;
            MATCH_CNT <= '0;
`ifdef SEQ_TX_PARITY_EN
            par       <= ^LOAD_DATA;
`endif
          end
        end
        ST_SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          bcnt <= bcnt - 1'b1;
          hist <= {hist[1:0], sreg[WIDTH-1]};
          if (fill != 2'd3) fill <= fill + 1'b1;
          if (hit && (MATCH_CNT != {CNT_W{1'b1}})) MATCH_CNT <= MATCH_CNT + 1'b1;
          if (bcnt == '0) begin
`ifdef SEQ_TX_PARITY_EN
            state <= ST_PAR;
`else
            state <= ST_DONE;
`endif
          end
        end
`ifdef SEQ_TX_PARITY_EN
        ST_PAR:  state <= ST_DONE;
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign LOAD_READY = (state == ST_IDLE);
  assign DONE       = (state == ST_DONE);

`ifdef SEQ_TX_PARITY_EN
  assign X_VALID = (state == ST_SHIFT) || (state == ST_PAR);
  assign X       = ((state == ST_SHIFT) && sreg[WIDTH-1]) || ((state == ST_PAR) && par);
`else
  assign X_VALID = (state == ST_SHIFT);
  assign X       = (state == ST_SHIFT) && sreg[WIDTH-1];
`endif

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: directed and random frames against a bit-list match model,
// plus a narrow instance for counter saturation.
module tb_seq_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int NB     = 25 + EXTRA;
  localparam int NB13   = 13 + EXTRA;
  localparam int PERIOD = 25 + 2 + EXTRA;

  logic        clk, rst;
  logic        lv, lr, x, xv, dn;
  logic [24:0] ld;
  logic [2:0]  mc;
  logic        lv2, lr2, x2, xv2, dn2;
  logic [12:0] ld2;
  logic [1:0]  mc2;

  int total = 0;
  int bad   = 0;

  seq_tx #(.WIDTH(25), .CNT_W(3)) dut (
    .CLK(clk), .RST(rst), .LOAD_VALID(lv), .LOAD_DATA(ld), .LOAD_READY(lr),
    .X(x), .X_VALID(xv), .DONE(dn), .MATCH_CNT(mc)
  );

  seq_tx #(.WIDTH(13), .CNT_W(2)) dut13 (
    .CLK(clk), .RST(rst), .LOAD_VALID(lv2), .LOAD_DATA(ld2), .LOAD_READY(lr2),
    .X(x2), .X_VALID(xv2), .DONE(dn2), .MATCH_CNT(mc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count of bit positions i>=3 where bits i-3..i read 1,0,0,1 (bit 0 = MSB).
  function automatic int model_matches(input logic [31:0] d, input int w, input int maxv);
    int n = 0;
    for (int i = 3; i < w; i++)
      if (d[w-1-i] && !d[w-i] && !d[w-i+1] && d[w-i+2]) n++;
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic run_frame(input logic [24:0] d, input string nm);
    int   exp_m;
    logic eb;
    exp_m = model_matches({7'b0, d}, 25, 7);
    @(negedge clk);
    total++;
    if (lr !== 1'b1) begin bad++; $display("FAIL %s ready: got %b want 1", nm, lr); end
    lv = 1'b1; ld = d;
    @(negedge clk);
    lv = 1'b0; ld = 25'($urandom);
    for (int i = 0; i < NB; i++) begin
      eb = (i < 25) ? d[24-i] : ^d;
      total++;
      if (xv !== 1'b1 || x !== eb || dn !== 1'b0) begin
        bad++; $display("FAIL %s bit%0d: x=%b xv=%b done=%b want x=%b xv=1 done=0", nm, i, x, xv, dn, eb);
      end
      @(negedge clk);
    end
    total++;
    if (dn !== 1'b1 || xv !== 1'b0 || x !== 1'b0 || lr !== 1'b0 || mc !== exp_m[2:0]) begin
      bad++; $display("FAIL %s done: done=%b xv=%b x=%b ready=%b cnt=%0d want 1/0/0/0 cnt=%0d",
                      nm, dn, xv, x, lr, mc, exp_m);
    end
    @(negedge clk);
    total++;
    if (dn !== 1'b0 || lr !== 1'b1 || mc !== exp_m[2:0]) begin
      bad++; $display("FAIL %s idle: done=%b ready=%b cnt=%0d want 0/1 cnt=%0d", nm, dn, lr, mc, exp_m);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; lv = 1'b0; ld = '0; lv2 = 1'b0; ld2 = '0;
    #2;
    total++;
    if (x !== 0 || xv !== 0 || dn !== 0 || mc !== 0 || lr !== 1 ||
        x2 !== 0 || xv2 !== 0 || dn2 !== 0 || mc2 !== 0 || lr2 !== 1) begin
      bad++; $display("FAIL reset: x=%b xv=%b done=%b cnt=%0d ready=%b (narrow %b%b%b%0d%b) want 0 0 0 0 1",
                      x, xv, dn, mc, lr, x2, xv2, dn2, mc2, lr2);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (lr !== 1'b1 || xv !== 1'b0 || dn !== 1'b0) begin
      bad++; $display("FAIL reset_release: ready=%b xv=%b done=%b want 1 0 0", lr, xv, dn);
    end
  endtask

  task automatic test_directed;
    run_frame(25'b1001001100100001001001001, "directed6");
    total++;
    if (mc !== 3'd6) begin bad++; $display("FAIL directed_cnt: got %0d want 6", mc); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) run_frame(25'($urandom), "random");
  endtask

  task automatic test_back_to_back;
    logic [24:0] d1, d2;
    int acc[2], dmc[2];
    int nacc = 0, ndone = 0, e1;
    logic chg = 1'b0;
    d1 = 25'($urandom);
    d2 = 25'h1FFFFFF;
    e1 = model_matches({7'b0, d1}, 25, 7);
    acc[0] = 0; acc[1] = 0; dmc[0] = 0; dmc[1] = 0;
    @(negedge clk);
    lv = 1'b1; ld = d1;
    for (int c = 0; c < 200 && ndone < 2; c++) begin
      if (dn === 1'b1) begin dmc[ndone] = int'(mc); ndone++; end
      if (lr === 1'b1 && lv && nacc < 2) begin acc[nacc] = c; nacc++; chg = 1'b1; end
      @(negedge clk);
      if (chg) begin
        chg = 1'b0;
        if (nacc == 1) ld = d2; else lv = 1'b0;
      end
    end
    lv = 1'b0;
    total++;
    if (nacc != 2 || ndone != 2) begin
      bad++; $display("FAIL b2b_timeout: accepts=%0d dones=%0d want 2 2", nacc, ndone);
    end
    total++;
    if (acc[1] - acc[0] != PERIOD) begin
      bad++; $display("FAIL b2b_period: got %0d want %0d", acc[1] - acc[0], PERIOD);
    end
    total++;
    if (dmc[0] != e1 || dmc[1] != 0) begin
      bad++; $display("FAIL b2b_cnt: got %0d,%0d want %0d,0", dmc[0], dmc[1], e1);
    end
  endtask

  task automatic test_saturate;
    logic [12:0] d;
    int   em, errs = 0;
    d  = 13'b1001001001001;
    em = model_matches({19'b0, d}, 13, 3);
    @(negedge clk);
    lv2 = 1'b1; ld2 = d;
    @(negedge clk);
    lv2 = 1'b0;
    for (int i = 0; i < NB13; i++) begin
      if (xv2 !== 1'b1 || x2 !== ((i < 13) ? d[12-i] : ^d)) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL sat_bits: %0d wrong bits want 0", errs); end
    total++;
    if (dn2 !== 1'b1 || mc2 !== em[1:0]) begin
      bad++; $display("FAIL sat_cnt: done=%b cnt=%0d want 1 cnt=%0d", dn2, mc2, em);
    end
    total++;
    if (mc2 !== 2'd3) begin bad++; $display("FAIL sat_max: got %0d want 3", mc2); end
  endtask

  task automatic test_mid_reset;
    logic [24:0] d;
    int   em, stray = 0;
    d  = 25'b1001001001001001001001001;
    em = model_matches({7'b0, d} >> 15, 10, 7);
    @(negedge clk);
    lv = 1'b1; ld = d;
    @(negedge clk);
    lv = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (xv !== 1'b1 || x !== d[14] || mc !== em[2:0]) begin
      bad++; $display("FAIL pre_reset: xv=%b x=%b cnt=%0d want 1 %b %0d", xv, x, mc, d[14], em);
    end
    rst = 1'b1;
    #1;
    total++;
    if (x !== 0 || xv !== 0 || mc !== 0 || dn !== 0 || lr !== 1) begin
      bad++; $display("FAIL mid_reset: x=%b xv=%b cnt=%0d done=%b ready=%b want 0 0 0 0 1", x, xv, mc, dn, lr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (dn !== 1'b0 || xv !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL no_done_after_abort: %0d stray cycles want 0", stray); end
    run_frame(25'($urandom), "after_reset");
  endtask

  task automatic test_cross_frame;
    run_frame({22'($urandom), 3'b100}, "tail100");
    run_frame({4'b1001, 21'b0}, "head1001");
    total++;
    if (mc !== 3'd1) begin bad++; $display("FAIL cross_frame: got %0d want 1", mc); end
  endtask

  task automatic test_parity;
    // 7 ones: parity bit is 1; run_frame checks it when parity is built in
    run_frame(25'b1010101000001010100000000, "parity7");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_saturate();
    test_mid_reset();
    test_cross_frame();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
